// File: rtl/mux_pkg.sv
// Shared definitions for the scan/select multiplexer: mode encodings and a
// constant-evaluable ceil(log2) used to size select and counter fields.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_next_ch.sv
// Round-robin search: the first enabled channel at (incl=1) or after (incl=0)
// a start index, wrapping N_CH-1 -> 0. Out-of-range starts wrap to channel 0.
module rr_next_ch
  import mux_pkg::*;
#(
  parameter  int N_CH = 16,
  localparam int SW   = clog2(N_CH)
) (
  input  logic [N_CH-1:0] mask,
  input  logic [SW-1:0]   start,
  input  logic            incl,
  output logic [SW-1:0]   next,
  output logic            any_en
);

  int unsigned base;
  int unsigned idx;
  logic        found;

  always_comb begin
    next  = '0;
    found = 1'b0;
    idx   = 32'd0;
    base  = (32'(start) >= 32'(N_CH)) ? 32'd0 : 32'(start);
    for (int k = 0; k < N_CH; k++) begin
      idx = (base + 32'(k) + (incl ? 32'd0 : 32'd1)) % 32'(N_CH);
      if (!found && mask[SW'(idx)]) begin
        next  = SW'(idx);
        found = 1'b1;
      end
    end
  end

  assign any_en = |mask;

endmodule

// File: rtl/mux_scan_reg.sv
// N-channel registered multiplexer with manual select or dwell-based
// round-robin auto scan, presenting samples over a valid/ready handshake.
module mux_scan_reg
  import mux_pkg::*;
#(
  parameter  int N_CH  = 16,
  parameter  int W     = 1,
  parameter  int DWELL = 1,
  localparam int SW    = clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] i,
  input  logic [SW-1:0]     s,
  input  logic              mode,
  input  logic [N_CH-1:0]   en_mask,
  output logic [W-1:0]      y,
  output logic [SW-1:0]     y_ch,
  output logic              y_valid,
  input  logic              y_ready
);

  localparam int DCW = (DWELL > 1) ? clog2(DWELL) : 1;

  logic [SW-1:0]  ptr;
  logic [DCW-1:0] dwell_cnt;
  logic           first;

  logic [SW-1:0]  first_idx;
  logic [SW-1:0]  adv_idx;
  logic           first_any;
  logic           adv_any;
  logic           mask_any;
  logic [SW-1:0]  sel;
  logic [DCW-1:0] dwell_now;
  logic           sel_en;
  logic           advance;
  logic           load;

  // Channel pick; indices beyond the last channel read as zero.
  function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] d,
                                        input logic [SW-1:0]     idx);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (32'(idx) == k) r = d[k*W +: W];
    end
    return r;
  endfunction

  rr_next_ch #(.N_CH(N_CH)) u_first (
    .mask   (en_mask),
    .start  (s),
    .incl   (1'b1),
    .next   (first_idx),
    .any_en (first_any)
  );

  rr_next_ch #(.N_CH(N_CH)) u_adv (
    .mask   (en_mask),
    .start  (sel),
    .incl   (1'b0),
    .next   (adv_idx),
    .any_en (adv_any)
  );

  assign mask_any  = first_any & adv_any;
  assign load      = !y_valid || y_ready;

  // The first auto load samples the start search directly, so the
  // dwell count behaves as if it had just been cleared.
  assign sel       = first ? first_idx : ptr;
  assign dwell_now = first ? '0 : dwell_cnt;
  assign sel_en    = |(en_mask & (N_CH'(1) << sel));
  assign advance   = (dwell_now == DCW'(DWELL - 1)) || !sel_en;

  // Output register stage: one clock from inputs to y
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y         <= '0;
      y_ch      <= '0;
      y_valid   <= 1'b0;
      ptr       <= '0;
      dwell_cnt <= '0;
      first     <= 1'b1;
    end else if (load) begin
      if (mode == MODE_MANUAL) begin
        y       <= pick(i, s);
        y_ch    <= s;
        y_valid <= 1'b1;
        first   <= 1'b1;
      end else if (!mask_any) begin
        y_valid <= 1'b0;
      end else begin
        y       <= pick(i, sel);
        y_ch    <= sel;
        y_valid <= 1'b1;
        first   <= 1'b0;
        if (advance) begin
          ptr       <= adv_idx;
          dwell_cnt <= '0;
        end else begin
          ptr       <= sel;
          dwell_cnt <= dwell_now + 1'b1;
        end
      end
    end
  end

endmodule
